// File: rtl/bus_timer_if.sv
// CPU data-bus responder signals for the timer's 16-byte window.
// The master drives the request; the timer (slave) returns combinational read data.
interface bus_timer_if;
  logic        sel;
  logic        we;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output sel, we, addr, wdata, input rdata);
  modport slave  (input sel, we, addr, wdata, output rdata);
endinterface

// File: rtl/bus_timer.sv
// Memory-mapped countdown timer with one-shot and auto-reload modes.
// Registers: CTRL (EN/MODE/IM), PRESET, COUNT (read-only); irq is registered.
module bus_timer (
  input  logic       clk,
  input  logic       rst_n,
  bus_timer_if.slave bus,
  output logic       irq
);

  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

  state_t      state;
  logic        en;
  logic [1:0]  mode;
  logic        im;
  logic        pend;
  logic [31:0] preset;
  logic [31:0] count;

  logic        ctrl_wr;
  logic        preset_wr;
  logic        auto_mode;
  logic        en_next;
  logic [1:0]  mode_next;
  logic        im_next;
  logic        pend_next;
  logic        unused_addr_bits;

  assign ctrl_wr          = bus.sel & bus.we & (bus.addr[3:2] == 2'd0);
  assign preset_wr        = bus.sel & bus.we & (bus.addr[3:2] == 2'd1);
  assign auto_mode        = (mode == 2'b01);
  assign unused_addr_bits = ^bus.addr[1:0];

  // A CPU write to CTRL overrides the one-shot EN-clear happening in the same cycle.
  always_comb begin
    en_next   = en;
    mode_next = mode;
    im_next   = im;
    pend_next = pend;
    if (state == INT && !auto_mode) begin
      en_next   = 1'b0;
      pend_next = 1'b1;
    end
    if (ctrl_wr) begin
      en_next   = bus.wdata[0];
      mode_next = bus.wdata[2:1];
      im_next   = bus.wdata[3];
      if (bus.wdata[0]) begin
        pend_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      en     <= 1'b0;
      mode   <= 2'b00;
      im     <= 1'b0;
      pend   <= 1'b0;
      preset <= '0;
      count  <= '0;
      irq    <= 1'b0;
    end else begin
      en   <= en_next;
      mode <= mode_next;
      im   <= im_next;
      pend <= pend_next;
      if (preset_wr) begin
        preset <= bus.wdata;
      end
      // Auto-reload pulses for the cycle after INT; one-shot holds while PEND is set.
      irq <= (state == INT && auto_mode) ? im_next : (pend_next & im_next);
      case (state)
        IDLE: begin
          if (en) begin
            state <= LOAD;
          end
        end
        LOAD: begin
          count <= preset;
          state <= CNT;
        end
        CNT: begin
          if (!en) begin
            state <= IDLE;
          end else if (count <= 32'd1) begin
            count <= '0;
            state <= INT;
          end else begin
            count <= count - 32'd1;
          end
        end
        INT: begin
          state <= auto_mode ? LOAD : IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    bus.rdata = '0;
    if (bus.sel) begin
      case (bus.addr[3:2])
        2'd0:    bus.rdata = {28'b0, im, mode, en};
        2'd1:    bus.rdata = preset;
        2'd2:    bus.rdata = count;
        default: bus.rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_timer.sv
// Self-checking bench for bus_timer: directed scenarios plus randomized bus traffic
// compared against a cycle-level behavioural model of the timer.
module tb_bus_timer;

  logic clk = 1'b0;
  logic rst_n;
  logic irq;

  bus_timer_if bus ();

  bus_timer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  localparam int PH_IDLE  = 0;
  localparam int PH_LOAD  = 1;
  localparam int PH_COUNT = 2;
  localparam int PH_FIRE  = 3;

  // Model of the timer as seen from the bus.
  int          m_phase  = PH_IDLE;
  logic        m_en     = 1'b0;
  logic [1:0]  m_mode   = 2'b00;
  logic        m_im     = 1'b0;
  logic        m_pend   = 1'b0;
  logic        m_irq    = 1'b0;
  logic [31:0] m_preset = '0;
  logic [31:0] m_count  = '0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [3:0] a);
    case (a[3:2])
      2'd0:    return {28'b0, m_im, m_mode, m_en};
      2'd1:    return m_preset;
      2'd2:    return m_count;
      default: return 32'd0;
    endcase
  endfunction

  task automatic tick();
    int          n_phase;
    logic        n_en, n_im, n_pend, n_irq, fired_auto, wr;
    logic [1:0]  n_mode, wa;
    logic [31:0] n_preset, n_count;
    wr = bus.sel & bus.we;
    wa = bus.addr[3:2];
    n_phase = m_phase; n_en = m_en; n_mode = m_mode; n_im = m_im;
    n_pend = m_pend; n_preset = m_preset; n_count = m_count;
    fired_auto = 1'b0;
    if (!rst_n) begin
      n_phase = PH_IDLE; n_en = 0; n_mode = 0; n_im = 0; n_pend = 0;
      n_preset = 0; n_count = 0; n_irq = 0;
    end else begin
      if (m_phase == PH_IDLE) begin
        if (m_en) n_phase = PH_LOAD;
      end else if (m_phase == PH_LOAD) begin
        n_count = m_preset;
        n_phase = PH_COUNT;
      end else if (m_phase == PH_COUNT) begin
        if (!m_en) n_phase = PH_IDLE;
        else if (m_count <= 1) begin n_count = 0; n_phase = PH_FIRE; end
        else n_count = m_count - 32'd1;
      end else begin
        if (m_mode == 2'b01) begin
          n_phase = PH_LOAD;
          fired_auto = 1'b1;
        end else begin
          n_pend = 1'b1;
          n_en = 1'b0;
          n_phase = PH_IDLE;
        end
      end
      if (wr && wa == 2'd0) begin
        n_en = bus.wdata[0];
        n_mode = bus.wdata[2:1];
        n_im = bus.wdata[3];
        if (bus.wdata[0]) n_pend = 1'b0;
      end
      if (wr && wa == 2'd1) n_preset = bus.wdata;
      n_irq = fired_auto ? n_im : (n_pend & n_im);
    end
    @(posedge clk);
    m_phase = n_phase; m_en = n_en; m_mode = n_mode; m_im = n_im;
    m_pend = n_pend; m_preset = n_preset; m_count = n_count; m_irq = n_irq;
    #1;
    checkOutput("irq_model", {31'b0, irq}, {31'b0, m_irq});
  endtask

  task automatic applyStimulus(input logic s, input logic w, input logic [3:0] a,
                               input logic [31:0] d);
    bus.sel   = s;
    bus.we    = w;
    bus.addr  = a;
    bus.wdata = d;
    tick();
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 4'h0, 32'd0);
  endtask

  task automatic readReg(input logic [3:0] a, output logic [31:0] v);
    bus.sel = 1'b1;
    bus.we  = 1'b0;
    bus.addr = a;
    #1;
    v = bus.rdata;
  endtask

  initial begin
    logic [31:0] v;
    logic        saw3, saw0;
    logic        rs, rw;
    logic [3:0]  ra, rd_addr;
    logic [31:0] rdv;

    $display("[TB] bus_timer bench starting");
    rst_n = 1'b0;
    bus.sel = 0; bus.we = 0; bus.addr = 0; bus.wdata = 0;
    idle(2);
    checkOutput("rst_irq", {31'b0, irq}, 32'd0);
    readReg(4'h0, v); checkOutput("rst_ctrl", v, 32'd0);
    rst_n = 1'b1;

    // One-shot, PRESET=5.
    applyStimulus(1, 1, 4'h4, 32'd5);
    applyStimulus(1, 1, 4'h0, 32'h9);
    for (int c = 1; c <= 10; c++) begin
      idle(1);
      readReg(4'h8, v);
      if (c >= 2 && c <= 7) checkOutput("os_count", v, 32'(7 - c));
      checkOutput("os_irq", {31'b0, irq}, {31'b0, (c >= 8)});
    end
    readReg(4'h0, v); checkOutput("os_ctrl_after", v, 32'h8);
    applyStimulus(1, 1, 4'h0, 32'h9);
    checkOutput("os_irq_clear", {31'b0, irq}, 32'd0);
    idle(2);
    readReg(4'h8, v); checkOutput("os_restart", v, 32'd5);
    idle(2);

    // Reset in the middle of a count.
    rst_n = 1'b0;
    idle(2);
    checkOutput("midrst_irq", {31'b0, irq}, 32'd0);
    for (int a = 0; a < 4; a++) begin
      readReg(4'(a * 4), v);
      checkOutput("midrst_read", v, 32'd0);
    end
    rst_n = 1'b1;

    // Auto-reload, PRESET=3: pulse every 5 cycles.
    applyStimulus(1, 1, 4'h4, 32'd3);
    applyStimulus(1, 1, 4'h0, 32'hB);
    for (int c = 1; c <= 22; c++) begin
      idle(1);
      checkOutput("ar_irq", {31'b0, irq}, {31'b0, (c >= 6 && (c - 6) % 5 == 0)});
    end
    applyStimulus(1, 1, 4'h0, 32'h3);
    saw3 = 0; saw0 = 0;
    for (int c = 0; c < 12; c++) begin
      idle(1);
      checkOutput("ar_masked_irq", {31'b0, irq}, 32'd0);
      readReg(4'h8, v);
      if (v == 32'd3) saw3 = 1;
      if (v == 32'd0) saw0 = 1;
    end
    checkOutput("ar_masked_cycles", {30'b0, saw3, saw0}, 32'd3);
    applyStimulus(1, 1, 4'h0, 32'h0);
    idle(2);

    // PRESET=0 gives the minimum period.
    applyStimulus(1, 1, 4'h4, 32'd0);
    applyStimulus(1, 1, 4'h0, 32'h9);
    for (int c = 1; c <= 4; c++) begin
      idle(1);
      readReg(4'h8, v);
      if (c == 2) checkOutput("p0_count", v, 32'd0);
      if (c == 3) checkOutput("p0_irq_early", {31'b0, irq}, 32'd0);
      if (c == 4) checkOutput("p0_irq", {31'b0, irq}, 32'd1);
    end
    applyStimulus(1, 1, 4'h0, 32'h0);

    // Largest preset decrements without wrapping.
    applyStimulus(1, 1, 4'h4, 32'hFFFF_FFFF);
    applyStimulus(1, 1, 4'h0, 32'h1);
    for (int c = 1; c <= 3; c++) begin
      idle(1);
      readReg(4'h8, v);
      if (c == 2) checkOutput("max_load", v, 32'hFFFF_FFFF);
      if (c == 3) checkOutput("max_dec", v, 32'hFFFF_FFFE);
    end
    applyStimulus(1, 1, 4'h0, 32'h0);
    idle(2);

    // PRESET rewrite mid-count takes effect only at the next reload.
    applyStimulus(1, 1, 4'h4, 32'd20);
    applyStimulus(1, 1, 4'h0, 32'h3);
    for (int c = 1; c <= 24; c++) begin
      if (c == 6) applyStimulus(1, 1, 4'h4, 32'd10);
      else idle(1);
      readReg(4'h8, v);
      if (c == 5)  checkOutput("pw_before", v, 32'd17);
      if (c == 7)  checkOutput("pw_unaffected", v, 32'd15);
      if (c == 24) checkOutput("pw_reload", v, 32'd10);
    end
    applyStimulus(1, 1, 4'h0, 32'h0);
    idle(2);

    // Clearing EN at COUNT=7 freezes the count.
    applyStimulus(1, 1, 4'h4, 32'd20);
    applyStimulus(1, 1, 4'h0, 32'h9);
    for (int c = 1; c <= 20; c++) begin
      if (c == 15) applyStimulus(1, 1, 4'h0, 32'h8);
      else idle(1);
      readReg(4'h8, v);
      if (c == 16 || c == 20) checkOutput("enclr_hold", v, 32'd7);
    end
    checkOutput("enclr_irq", {31'b0, irq}, 32'd0);

    // Bus hygiene.
    applyStimulus(0, 1, 4'h0, 32'hF);
    readReg(4'h0, v); checkOutput("nosel_ctrl", v, 32'h8);
    bus.sel = 1'b0; bus.addr = 4'h4; #1;
    checkOutput("nosel_rdata", bus.rdata, 32'd0);
    applyStimulus(1, 1, 4'h8, 32'h1234);
    readReg(4'h8, v); checkOutput("count_ro", v, 32'd7);
    applyStimulus(1, 1, 4'hC, 32'hFFFF);
    readReg(4'hC, v); checkOutput("rsvd_read", v, 32'd0);
    readReg(4'h4, v); checkOutput("preset_keep", v, 32'd20);
    applyStimulus(1, 1, 4'h0, 32'hFFFF_FFFF);
    readReg(4'h0, v); checkOutput("ctrl_mask", v, 32'hF);
    applyStimulus(1, 1, 4'h0, 32'h0);
    idle(3);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 63) != 0);
      rs = ($urandom_range(0, 3) != 0);
      rw = ($urandom_range(0, 3) == 0);
      ra = 4'($urandom_range(0, 15));
      rdv = (ra[3:2] == 2'd1) ? 32'($urandom_range(0, 6)) : 32'($urandom);
      applyStimulus(rs, rw, ra, rdv);
      rd_addr = 4'($urandom_range(0, 15));
      readReg(rd_addr, v);
      checkOutput("rand_read", v, m_read(rd_addr));
    end
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
